// File: rtl/spi_cmd_rx.sv
// ============================================================================
// Module      : spi_cmd_rx
// Description : Two-wire SPI command receiver for the sprite/SVGA generator.
//               Frames are delimited by an idle timeout. Optional macro
//               SHADOW_REGS_EN makes colour/position writes commit on
//               next_frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_cmd_rx #(
    parameter int IDLE_CYCLES  = 256,
    parameter int SPRITE_BYTES = 18
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       spi_clk,
    input  logic       spi_data,
    input  logic       next_frame,
    output logic [5:0] bg_color,
    output logic [5:0] fg_color,
    output logic [9:0] sprite_x,
    output logic [9:0] sprite_y,
    output logic       sprite_we,
    output logic [4:0] sprite_addr,
    output logic [7:0] sprite_wdata
);

    localparam int c_IDLE_W = $clog2(IDLE_CYCLES + 1);

    localparam logic [2:0] c_ST_CMD    = 3'd0;
    localparam logic [2:0] c_ST_COLOR  = 3'd1;
    localparam logic [2:0] c_ST_POSX   = 3'd2;
    localparam logic [2:0] c_ST_POSY   = 3'd3;
    localparam logic [2:0] c_ST_SPRITE = 3'd4;
    localparam logic [2:0] c_ST_IGNORE = 3'd5;

    logic                r_clk_s1, r_clk_s2, r_clk_s3;
    logic                r_dat_s1, r_dat_s2;
    logic [7:0]          r_shift;
    logic [2:0]          r_bit_cnt;
    logic [c_IDLE_W-1:0] r_idle;
    logic [2:0]          r_state, w_next;
    logic                r_have_b1;
    logic [5:0]          r_b1;
    logic [4:0]          r_addr;
    logic                r_sprite_we;
    logic [4:0]          r_sprite_addr;
    logic [7:0]          r_sprite_wdata;
    logic [5:0]          r_bg, r_fg;
    logic [9:0]          r_x, r_y;

    logic                w_rise, w_edge, w_byte_done, w_timeout;
    logic [7:0]          w_byte;
    logic                w_take_b1, w_wr_color, w_wr_posx, w_wr_posy, w_wr_sprite;

    assign w_rise      = r_clk_s2 & ~r_clk_s3;
    assign w_edge      = r_clk_s2 ^ r_clk_s3;
    assign w_byte      = {r_shift[6:0], r_dat_s2};
    assign w_byte_done = w_rise && (r_bit_cnt == 3'd7);
    assign w_timeout   = (r_idle == c_IDLE_W'(IDLE_CYCLES));

    // Input synchronizers plus edge-detect stage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_s1 <= 1'b0;
            r_clk_s2 <= 1'b0;
            r_clk_s3 <= 1'b0;
            r_dat_s1 <= 1'b0;
            r_dat_s2 <= 1'b0;
        end else begin
            r_clk_s1 <= spi_clk;
            r_clk_s2 <= r_clk_s1;
            r_clk_s3 <= r_clk_s2;
            r_dat_s1 <= spi_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift   <= 8'd0;
            r_bit_cnt <= 3'd0;
            r_idle    <= '0;
        end else begin
            if (w_edge)
                r_idle <= '0;
            else if (!w_timeout)
                r_idle <= r_idle + 1'b1;

            if (w_rise) begin
                r_shift   <= w_byte;
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end else if (w_timeout) begin
                r_bit_cnt <= 3'd0;
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= c_ST_CMD;
        else          r_state <= w_next;
    end

    // FSM: next state; a completed byte wins over timeout
    always_comb begin
        w_next = r_state;
        if (w_byte_done) begin
            case (r_state)
                c_ST_CMD: begin
                    case (w_byte)
                        8'h01:   w_next = c_ST_COLOR;
                        8'h02:   w_next = c_ST_POSX;
                        8'h03:   w_next = c_ST_POSY;
                        8'h04:   w_next = c_ST_SPRITE;
                        default: w_next = c_ST_IGNORE;
                    endcase
                end
                c_ST_COLOR, c_ST_POSX, c_ST_POSY:
                    if (r_have_b1) w_next = c_ST_IGNORE;
                c_ST_SPRITE:
                    if (r_addr == 5'(SPRITE_BYTES - 1)) w_next = c_ST_IGNORE;
                default: w_next = r_state;
            endcase
        end else if (w_timeout) begin
            w_next = c_ST_CMD;
        end
    end

    // FSM: outputs (write strobes for the registered datapath)
    always_comb begin
        w_take_b1   = 1'b0;
        w_wr_color  = 1'b0;
        w_wr_posx   = 1'b0;
        w_wr_posy   = 1'b0;
        w_wr_sprite = 1'b0;
        if (w_byte_done) begin
            case (r_state)
                c_ST_COLOR:  begin w_take_b1 = !r_have_b1; w_wr_color = r_have_b1; end
                c_ST_POSX:   begin w_take_b1 = !r_have_b1; w_wr_posx  = r_have_b1; end
                c_ST_POSY:   begin w_take_b1 = !r_have_b1; w_wr_posy  = r_have_b1; end
                c_ST_SPRITE: w_wr_sprite = 1'b1;
                default:     w_take_b1   = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_have_b1      <= 1'b0;
            r_b1           <= 6'd0;
            r_addr         <= 5'd0;
            r_sprite_we    <= 1'b0;
            r_sprite_addr  <= 5'd0;
            r_sprite_wdata <= 8'd0;
        end else begin
            if (w_take_b1) begin
                r_have_b1 <= 1'b1;
                r_b1      <= w_byte[5:0];
            end else if (w_wr_color || w_wr_posx || w_wr_posy || w_timeout) begin
                r_have_b1 <= 1'b0;
            end

            if (w_byte_done && r_state == c_ST_CMD)
                r_addr <= 5'd0;
            else if (w_wr_sprite)
                r_addr <= r_addr + 5'd1;

            r_sprite_we <= w_wr_sprite;
            if (w_wr_sprite) begin
                r_sprite_addr  <= r_addr;
                r_sprite_wdata <= w_byte;
            end
        end
    end

`ifdef SHADOW_REGS_EN
    logic [5:0] r_sh_bg, r_sh_fg;
    logic [9:0] r_sh_x, r_sh_y;

    // Live registers take the shadow value present when next_frame is seen
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sh_bg <= 6'h00;
            r_sh_fg <= 6'h3F;
            r_sh_x  <= 10'd0;
            r_sh_y  <= 10'd0;
            r_bg    <= 6'h00;
            r_fg    <= 6'h3F;
            r_x     <= 10'd0;
            r_y     <= 10'd0;
        end else begin
            if (w_wr_color) begin
                r_sh_bg <= r_b1;
                r_sh_fg <= w_byte[5:0];
            end
            if (w_wr_posx) r_sh_x <= {r_b1[1:0], w_byte};
            if (w_wr_posy) r_sh_y <= {r_b1[1:0], w_byte};
            if (next_frame) begin
                r_bg <= r_sh_bg;
                r_fg <= r_sh_fg;
                r_x  <= r_sh_x;
                r_y  <= r_sh_y;
            end
        end
    end
`else
    logic w_unused_next_frame;
    assign w_unused_next_frame = next_frame;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bg <= 6'h00;
            r_fg <= 6'h3F;
            r_x  <= 10'd0;
            r_y  <= 10'd0;
        end else begin
            if (w_wr_color) begin
                r_bg <= r_b1;
                r_fg <= w_byte[5:0];
            end
            if (w_wr_posx) r_x <= {r_b1[1:0], w_byte};
            if (w_wr_posy) r_y <= {r_b1[1:0], w_byte};
        end
    end
`endif

    assign bg_color     = r_bg;
    assign fg_color     = r_fg;
    assign sprite_x     = r_x;
    assign sprite_y     = r_y;
    assign sprite_we    = r_sprite_we;
    assign sprite_addr  = r_sprite_addr;
    assign sprite_wdata = r_sprite_wdata;

endmodule

`default_nettype wire

// File: tb/tb_spi_cmd_rx.sv
// ============================================================================
// Module      : tb_spi_cmd_rx
// Description : Self-checking bench for spi_cmd_rx (both SHADOW_REGS_EN builds).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_cmd_rx;

    localparam int c_IDLE   = 64;
    localparam int c_SPR    = 18;
    localparam int c_PHASE  = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       spi_clk;
    logic       spi_data;
    logic       next_frame;
    logic [5:0] bg_color, fg_color;
    logic [9:0] sprite_x, sprite_y;
    logic       sprite_we;
    logic [4:0] sprite_addr;
    logic [7:0] sprite_wdata;

    int checks = 0;
    int errors = 0;
    int we_count = 0;
    logic [12:0] sb[$];

    spi_cmd_rx #(.IDLE_CYCLES(c_IDLE), .SPRITE_BYTES(c_SPR)) dut (
        .clk(clk), .reset_n(reset_n), .spi_clk(spi_clk), .spi_data(spi_data),
        .next_frame(next_frame), .bg_color(bg_color), .fg_color(fg_color),
        .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_we(sprite_we),
        .sprite_addr(sprite_addr), .sprite_wdata(sprite_wdata)
    );

    always #5 clk = ~clk;

    // Scoreboard side: every bitmap write must match the next queued entry
    always @(negedge clk) begin
        if (reset_n && sprite_we) begin
            logic [12:0] exp;
            we_count++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sprite_we_unexpected: got addr=%0d data=%02h, required no write",
                         sprite_addr, sprite_wdata);
            end else begin
                exp = sb.pop_front();
                if ({sprite_addr, sprite_wdata} !== exp) begin
                    errors++;
                    $display("FAIL sprite_write: got addr=%0d data=%02h, required addr=%0d data=%02h",
                             sprite_addr, sprite_wdata, exp[12:8], exp[7:0]);
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        spi_clk  = 1'b0;
        spi_data = b;
        wait_cyc(c_PHASE);
        spi_clk  = 1'b1;
        wait_cyc(c_PHASE);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic end_frame();
        spi_clk = 1'b0;
        wait_cyc(c_IDLE + 8);
    endtask

    task automatic pulse_nf();
        next_frame = 1'b1;
        wait_cyc(1);
        next_frame = 1'b0;
        wait_cyc(1);
    endtask

    task automatic check_regs(input string name, input logic [5:0] bg, input logic [5:0] fg,
                              input logic [9:0] x, input logic [9:0] y);
        checks++;
        if ({bg_color, fg_color, sprite_x, sprite_y} !== {bg, fg, x, y}) begin
            errors++;
            $display("FAIL %s: got bg=%02h fg=%02h x=%03h y=%03h, required bg=%02h fg=%02h x=%03h y=%03h",
                     name, bg_color, fg_color, sprite_x, sprite_y, bg, fg, x, y);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; spi_clk = 1'b0; spi_data = 1'b0; next_frame = 1'b0;
        wait_cyc(3);
        reset_n = 1'b1;
        wait_cyc(1);
        check_regs("reset_regs", 6'h00, 6'h3F, 10'd0, 10'd0);
        checks++;
        if ({sprite_we, sprite_addr, sprite_wdata} !== 14'd0) begin
            errors++;
            $display("FAIL reset_sprite: got we=%b addr=%0d data=%02h, required 0/0/00",
                     sprite_we, sprite_addr, sprite_wdata);
        end
        wait_cyc(1000);
        pulse_nf();
        check_regs("idle_hold", 6'h00, 6'h3F, 10'd0, 10'd0);
    endtask

    task automatic test_color();
        send_byte(8'h01); send_byte(8'h05); send_byte(8'h2A);
        end_frame();
`ifdef SHADOW_REGS_EN
        check_regs("color_before_nf", 6'h00, 6'h3F, 10'd0, 10'd0);
        pulse_nf();
`endif
        check_regs("color_write", 6'h05, 6'h2A, 10'd0, 10'd0);
    endtask

    task automatic test_position();
        send_byte(8'h02); send_byte(8'hFF); send_byte(8'h34);
        end_frame();
        pulse_nf();
        check_regs("posx_write", 6'h05, 6'h2A, 10'h334, 10'd0);
        send_byte(8'h03); send_byte(8'h01);
        end_frame();
        pulse_nf();
        check_regs("posy_timeout", 6'h05, 6'h2A, 10'h334, 10'd0);
        // A fresh POSY frame after the timeout must decode from CMD
        send_byte(8'h03); send_byte(8'h02); send_byte(8'h9C);
        end_frame();
        pulse_nf();
        check_regs("posy_write", 6'h05, 6'h2A, 10'h334, 10'h29C);
    endtask

    task automatic test_sprite();
        int start;
        start = we_count;
        send_byte(8'h04);
        for (int i = 0; i < 20; i++) begin
            logic [7:0] d;
            d = 8'h80 + 8'(i);
            if (i < c_SPR) sb.push_back({5'(i), d});
            send_byte(d);
        end
        end_frame();
        checks++;
        if (we_count - start != c_SPR || sb.size() != 0) begin
            errors++;
            $display("FAIL sprite_count: got %0d pulses (%0d pending), required %0d pulses (0 pending)",
                     we_count - start, sb.size(), c_SPR);
            sb.delete();
        end
        pulse_nf();
        check_regs("sprite_no_side_effect", 6'h05, 6'h2A, 10'h334, 10'h29C);
    endtask

    task automatic test_ignore();
        send_byte(8'h77); send_byte(8'h01); send_byte(8'h11); send_byte(8'h22);
        end_frame();
        pulse_nf();
        check_regs("ignore_unknown", 6'h05, 6'h2A, 10'h334, 10'h29C);
    endtask

    task automatic test_reset_mid();
        send_byte(8'h01); send_byte(8'h12);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        reset_n = 1'b0;
        #1;
        check_regs("async_reset", 6'h00, 6'h3F, 10'd0, 10'd0);
        wait_cyc(3);
        spi_clk = 1'b0;
        wait_cyc(2);
        reset_n = 1'b1;
        wait_cyc(c_IDLE + 8);
        pulse_nf();
        check_regs("after_reset_idle", 6'h00, 6'h3F, 10'd0, 10'd0);
        send_byte(8'h01); send_byte(8'h15); send_byte(8'h0A);
        end_frame();
        pulse_nf();
        check_regs("color_after_reset", 6'h15, 6'h0A, 10'd0, 10'd0);
    endtask

    task automatic test_back_to_back();
        // Two complete commands separated only by the idle timeout
        send_byte(8'h01); send_byte(8'hC7); send_byte(8'hFB);
        end_frame();
        send_byte(8'h02); send_byte(8'h01); send_byte(8'h00);
        end_frame();
        pulse_nf();
        check_regs("back_to_back", 6'h07, 6'h3B, 10'h100, 10'd0);
    endtask

    initial begin
        test_reset();
        test_color();
        test_position();
        test_sprite();
        test_ignore();
        test_reset_mid();
        test_back_to_back();
        wait_cyc(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_cmd_rx.md
# spi_cmd_rx

Command receiver between the two-wire SPI inputs (`spi_clk`, `spi_data`) and the sprite/SVGA generator. Synchronizes the asynchronous serial pins into `clk`, assembles MSB-first bytes, frames them by idle timeout (no chip select exists), and decodes commands. Commands update sprite colours, sprite position and the 12x12 1bpp sprite bitmap. With shadowing compiled in, colour and position changes are committed only on the generator's `next_frame` pulse, so the picture never tears.

## Interface
Parameters:
- `IDLE_CYCLES`, 256: number of `clk` cycles without a synchronized `spi_clk` edge after which the frame resets. Minimum 8.
- `SPRITE_BYTES`, 18: bitmap length in bytes (144 bits).

Ports:
- `clk` in 1: system clock (pixel clock).
- `reset_n` in 1: asynchronous, active-low reset.
- `spi_clk` in 1: serial clock, asynchronous to `clk`.
- `spi_data` in 1: serial data, sampled on the `spi_clk` rising edge.
- `next_frame` in 1: one-cycle pulse from the SVGA stage at the frame boundary.
- `bg_color` out 6: background RRGGBB.
- `fg_color` out 6: sprite RRGGBB.
- `sprite_x` out 10: sprite left column.
- `sprite_y` out 10: sprite top row.
- `sprite_we` out 1: bitmap write strobe, one cycle per byte.
- `sprite_addr` out 5: bitmap byte address, 0..SPRITE_BYTES-1.
- `sprite_wdata` out 8: bitmap byte (MSB = leftmost pixel).

## Operation
- Input path: a 2-FF synchronizer on each of `spi_clk` and `spi_data`. A third register on `spi_clk` provides edge detection.
- On each synchronized rising edge: shift the synchronized data into an 8-bit register (MSB first) and increment a 3-bit bit counter.
- Byte complete: occurs on the 8th bit. The counter wraps to 0.
- Frame reset: any synchronized edge (rising or falling) clears the idle counter. When the idle counter reaches `IDLE_CYCLES`, the FSM returns to CMD, the bit counter clears, and partial bytes and pending first bytes are discarded. The idle counter saturates and does not wrap.
- FSM states:
  - CMD: the first complete byte is the opcode.
    - 0x01 goes to COLOR.
    - 0x02 goes to POSX.
    - 0x03 goes to POSY.
    - 0x04 goes to SPRITE with address 0.
    - Any other value goes to IGNORE.
  - COLOR, POSX, POSY: expect 2 data bytes.
    - Byte 1 is held in a temp register.
    - On byte 2, perform the write, then go to IGNORE.
    - COLOR writes `bg <= b1[5:0]` and `fg <= b2[5:0]`.
    - POSX and POSY write `{b1[1:0], b2}`; b1[7:2] is ignored.
  - SPRITE: each byte pulses `sprite_we` with the current address, and the address increments. After byte `SPRITE_BYTES-1` is written, go to IGNORE.
  - IGNORE: bytes are discarded until timeout.
- Shadowing: the position and colour writes above target the shadow registers (see Configuration).
- Sprite bitmap writes are never shadowed.

## Timing
- Input latency: a `spi_clk` rising edge on the pin is shifted 3 `clk` cycles later (2 sync + 1 edge-detect).
- Output latency: register writes and `sprite_we` are registered and become visible 1 cycle after the cycle in which the 8th bit shifts.
- SPI constraint: each `spi_clk` high and low phase must last at least 3 `clk` cycles. `spi_data` must be stable 3 cycles around the rising edge.
- Reset values of outputs:
  - `bg_color` = 0x00, `fg_color` = 0x3F.
  - `sprite_x` = 0, `sprite_y` = 0.
  - `sprite_we` = 0, `sprite_addr` = 0, `sprite_wdata` = 0.
- Reset state of internal logic: FSM = CMD, all counters 0, shadow registers equal the live reset values.
- Reset mid-frame: everything returns to reset values immediately (asynchronously). A partial transfer has no effect.
- Timeout after byte 1 of a 2-byte command: nothing is written.
- `next_frame` in the same cycle as a shadow write: the live registers take the old shadow value. The new value is committed at the following `next_frame`.
- Timeout and byte completion in the same cycle: cannot occur, because an edge clears the idle counter. Edge handling takes priority.

## Configuration
- `SHADOW_REGS_EN`:
  - Defined: colour and position writes go to the shadow registers. The live outputs load all four shadows in the cycle after a `next_frame` pulse.
  - Undefined: there are no shadow registers. Writes update the live outputs directly at the output latency, and `next_frame` is unused.

## Test plan
- Reset only, then 1000 idle cycles -> outputs hold their reset values; `sprite_we` never asserts.
- Send 0x01, 0x05, 0x2A, then wait `IDLE_CYCLES` -> `bg_color` = 0x05 and `fg_color` = 0x2A. With the macro defined, this happens only after the next `next_frame`; without it, 1 cycle after the last bit.
- Send 0x02, 0xFF, 0x34 -> `sprite_x` = 0x334. Then send 0x03, 0x01, then time out -> `sprite_y` stays 0.
- Send 0x04 followed by 20 bytes 0x80..0x93 -> 18 `sprite_we` pulses at addr 0..17 with data 0x80..0x91; bytes 0x92 and 0x93 are ignored.
- Send 0x77 then 0x01 0x05 0x2A within the same frame (no timeout) -> no change, because the FSM is in IGNORE.
- Assert `reset_n` low after 4 bits of byte 2 of a COLOR command -> values return to reset; a fresh COLOR frame afterwards decodes correctly.
